// File: rtl/user_ctrl_regs_if.sv
// user_ctrl_regs_if: Wishbone slave bus bundle for the user control block
interface user_ctrl_regs_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/user_ctrl_regs.sv
// user_ctrl_regs: Wishbone control block for reset sequencing, button debounce, frame count and IRQ
module user_ctrl_regs #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter logic [15:0] DBNC_DEFAULT = 16'd50000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    user_ctrl_regs_if.slave wb,
    input  logic [5:0]      btn_i,
    input  logic            vsync_i,
    output logic            core_rst_o,
    output logic            game_rst_o,
    output logic [5:0]      btn_o,
    output logic            irq_o
);
    logic        hit;
    logic        req;
    logic        wr;
    logic [5:0]  off;
    logic [31:0] rdata;
    logic [1:0]  ctrl_rst;
    logic [5:0]  irq_mask;
    logic [15:0] frame;
    logic [15:0] dbnc;
    logic [15:0] period;
    logic [5:0]  edges;
    logic [5:0]  edge_clr;
    logic [5:0]  fire;
    logic [5:0]  btn_s1;
    logic [5:0]  btn_s2;
    logic [15:0] cnt [6];
    logic        vs_s1;
    logic        vs_s2;
    logic        vs_q;
    logic        vs_rise;
    logic        unused_bits;

    assign unused_bits = ^{wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:16], wb.wbs_sel_i[3:2]};

    // Request decode, write strobes and read-data mux
    always_comb begin
        hit      = wb.wbs_adr_i[31:8] == BASE_ADDR[31:8];
        req      = wb.wbs_stb_i && wb.wbs_cyc_i && hit && !wb.wbs_ack_o;
        wr       = req && wb.wbs_we_i;
        off      = wb.wbs_adr_i[7:2];
        edge_clr = (wr && off == 6'h04 && wb.wbs_sel_i[0]) ? wb.wbs_dat_i[5:0] : 6'd0;
        vs_rise  = vs_s2 && !vs_q;
        rdata    = (off == 6'h00) ? {18'd0, irq_mask, 6'd0, ctrl_rst} :
                   (off == 6'h01) ? {18'd0, btn_s2, 2'd0, btn_o} :
                   (off == 6'h02) ? {16'd0, frame} :
                   (off == 6'h03) ? {16'd0, dbnc} :
                   (off == 6'h04) ? {26'd0, edges} : 32'd0;
    end

    // Debounce fire condition; a zero period behaves as one
    always_comb begin
        period = (dbnc == 16'd0) ? 16'd1 : dbnc;
        for (int i = 0; i < 6; i++)
            fire[i] = (btn_s2[i] != btn_o[i]) && (cnt[i] >= period);
    end

    // Single-cycle ack; read data only while ack is high
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_dat_o <= 32'd0;
        end else begin
            wb.wbs_ack_o <= req;
            wb.wbs_dat_o <= (req && !wb.wbs_we_i) ? rdata : 32'd0;
        end
    end

    // CTRL and DBNC byte-lane writes, registered reset outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_rst   <= 2'b11;
            irq_mask   <= 6'd0;
            dbnc       <= DBNC_DEFAULT;
            core_rst_o <= 1'b1;
            game_rst_o <= 1'b1;
        end else begin
            if (wr && off == 6'h00 && wb.wbs_sel_i[0]) ctrl_rst <= wb.wbs_dat_i[1:0];
            if (wr && off == 6'h00 && wb.wbs_sel_i[1]) irq_mask <= wb.wbs_dat_i[13:8];
            if (wr && off == 6'h03 && wb.wbs_sel_i[0]) dbnc[7:0] <= wb.wbs_dat_i[7:0];
            if (wr && off == 6'h03 && wb.wbs_sel_i[1]) dbnc[15:8] <= wb.wbs_dat_i[15:8];
            core_rst_o <= ctrl_rst[0];
            game_rst_o <= ctrl_rst[1];
        end
    end

    // Two-stage synchronizers for buttons and vsync, plus vsync edge history
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            btn_s1 <= 6'd0;
            btn_s2 <= 6'd0;
            vs_s1  <= 1'b0;
            vs_s2  <= 1'b0;
            vs_q   <= 1'b0;
        end else begin
            btn_s1 <= btn_i;
            btn_s2 <= btn_s1;
            vs_s1  <= vsync_i;
            vs_s2  <= vs_s1;
            vs_q   <= vs_s2;
        end
    end

    // Per-button run counters; output toggles once the mismatch has lasted the period
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < 6; i++) cnt[i] <= 16'd0;
            btn_o <= 6'd0;
        end else begin
            for (int i = 0; i < 6; i++)
                cnt[i] <= (btn_s2[i] == btn_o[i] || fire[i]) ? 16'd0 : cnt[i] + 16'd1;
            btn_o <= btn_o ^ fire;
        end
    end

    // Sticky press latch (set beats clear) and registered level IRQ
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            edges <= 6'd0;
            irq_o <= 1'b0;
        end else begin
            edges <= (edges & ~edge_clr) | (fire & ~btn_o);
            irq_o <= |(edges & irq_mask);
        end
    end

    // Frame counter; a write clears it even on a coincident vsync edge
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            frame <= 16'd0;
        else
            frame <= (wr && off == 6'h02) ? 16'd0 : frame + {15'd0, vs_rise};
    end
endmodule

// File: tb/tb_user_ctrl_regs.sv
`timescale 1ns/1ps
// tb_user_ctrl_regs: directed and randomized checks of user_ctrl_regs against a behavioural model
module tb_user_ctrl_regs;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  btn_i = 6'd0;
    logic        vsync_i = 1'b0;
    logic        core_rst_o;
    logic        game_rst_o;
    logic [5:0]  btn_o;
    logic        irq_o;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en = 1'b0;
    logic [31:0] d;

    user_ctrl_regs_if bus_if();

    user_ctrl_regs #(.BASE_ADDR(BASE), .DBNC_DEFAULT(16'd50000)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus_if.slave), .btn_i(btn_i), .vsync_i(vsync_i),
        .core_rst_o(core_rst_o), .game_rst_o(game_rst_o), .btn_o(btn_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: registers as plain variables, buttons as run lengths of disagreement
    logic [31:0] m_dat;
    logic        m_ack, m_core, m_game, m_irq;
    logic [1:0]  m_rst;
    logic [5:0]  m_mask, m_btn, m_edge;
    logic [15:0] m_frame, m_dbnc;
    logic [5:0]  bh0, bh1, bh2;
    logic        vh0, vh1, vh2, vh3;
    int          run [6];

    always @(posedge clk) begin : model
        logic        req, wr;
        logic [5:0]  off, nb, clr;
        logic [31:0] rd;
        int          p;
        if (rst) begin
            m_dat = 0; m_ack = 0; m_core = 1; m_game = 1; m_irq = 0;
            m_rst = 2'b11; m_mask = 0; m_btn = 0; m_edge = 0; m_frame = 0; m_dbnc = 16'd50000;
            bh0 = 0; bh1 = 0; bh2 = 0; vh0 = 0; vh1 = 0; vh2 = 0; vh3 = 0;
            for (int i = 0; i < 6; i++) run[i] = 0;
        end else begin
            bh2 = bh1; bh1 = bh0; bh0 = btn_i;
            vh3 = vh2; vh2 = vh1; vh1 = vh0; vh0 = vsync_i;
            req = bus_if.wbs_stb_i && bus_if.wbs_cyc_i && (bus_if.wbs_adr_i[31:8] == BASE[31:8]) && !m_ack;
            wr  = req && bus_if.wbs_we_i;
            off = bus_if.wbs_adr_i[7:2];
            case (off)
                6'd0:    rd = {18'd0, m_mask, 6'd0, m_rst};
                6'd1:    rd = {18'd0, bh2, 2'd0, m_btn};
                6'd2:    rd = {16'd0, m_frame};
                6'd3:    rd = {16'd0, m_dbnc};
                6'd4:    rd = {26'd0, m_edge};
                default: rd = 0;
            endcase
            p  = (m_dbnc == 0) ? 1 : int'(m_dbnc);
            nb = m_btn;
            for (int i = 0; i < 6; i++) begin
                run[i] = (bh2[i] != m_btn[i]) ? run[i] + 1 : 0;
                if (run[i] > p) begin
                    nb[i]  = ~m_btn[i];
                    run[i] = 0;
                end
            end
            m_irq  = |(m_edge & m_mask);
            m_core = m_rst[0];
            m_game = m_rst[1];
            clr    = (wr && off == 6'd4 && bus_if.wbs_sel_i[0]) ? bus_if.wbs_dat_i[5:0] : 6'd0;
            m_edge = (m_edge & ~clr) | (nb & ~m_btn);
            m_btn  = nb;
            if (wr && off == 6'd2) m_frame = 0;
            else if (vh2 && !vh3) m_frame = m_frame + 1;
            if (wr && off == 6'd0 && bus_if.wbs_sel_i[0]) m_rst = bus_if.wbs_dat_i[1:0];
            if (wr && off == 6'd0 && bus_if.wbs_sel_i[1]) m_mask = bus_if.wbs_dat_i[13:8];
            if (wr && off == 6'd3 && bus_if.wbs_sel_i[0]) m_dbnc[7:0] = bus_if.wbs_dat_i[7:0];
            if (wr && off == 6'd3 && bus_if.wbs_sel_i[1]) m_dbnc[15:8] = bus_if.wbs_dat_i[15:8];
            m_dat = (req && !bus_if.wbs_we_i) ? rd : 0;
            m_ack = req;
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            check("mon_ack", bus_if.wbs_ack_o, m_ack);
            check("mon_dat", bus_if.wbs_dat_o, m_dat);
            check("mon_btn", btn_o, m_btn);
            check("mon_irq", irq_o, m_irq);
            check("mon_core", core_rst_o, m_core);
            check("mon_game", game_rst_o, m_game);
        end
    end

    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rd);
        @(posedge clk); #1;
        bus_if.wbs_stb_i = 1; bus_if.wbs_cyc_i = 1; bus_if.wbs_we_i = we;
        bus_if.wbs_adr_i = adr; bus_if.wbs_dat_i = dat; bus_if.wbs_sel_i = sel;
        @(posedge clk); #1;
        check("ack_n1", bus_if.wbs_ack_o, (adr[31:8] == BASE[31:8]) ? 1 : 0);
        rd = bus_if.wbs_dat_o;
        bus_if.wbs_stb_i = 0; bus_if.wbs_cyc_i = 0; bus_if.wbs_we_i = 0;
        @(posedge clk); #1;
        check("ack_drop", bus_if.wbs_ack_o, 0);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] x;
        bus(1'b1, BASE + {24'd0, off}, dat, sel, x);
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] q);
        bus(1'b0, BASE + {24'd0, off}, 32'd0, 4'hF, q);
    endtask

    initial begin
        bus_if.wbs_stb_i = 0; bus_if.wbs_cyc_i = 0; bus_if.wbs_we_i = 0;
        bus_if.wbs_sel_i = 0; bus_if.wbs_dat_i = 0; bus_if.wbs_adr_i = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        mon_en = 1;
        check("core_rst_reset", core_rst_o, 1);
        check("game_rst_reset", game_rst_o, 1);
        rd(8'h00, d); check("ctrl_reset", d, 32'h3);
        rd(8'h0C, d); check("dbnc_reset", d, 32'd50000);

        wr(8'h00, 32'h0000_3F00, 4'b0010);
        rd(8'h00, d); check("ctrl_mask", d, 32'h3F03);
        wr(8'h00, 32'h0, 4'b0001);
        check("core_rst_off", core_rst_o, 0);
        check("game_rst_off", game_rst_o, 0);

        wr(8'h0C, 32'd4, 4'hF);
        @(posedge clk); #1 btn_i = 6'h01;
        repeat (3) @(posedge clk);
        #1 btn_i = 6'h00;
        repeat (12) @(posedge clk); #1;
        check("glitch_btn", btn_o, 0);
        btn_i = 6'h01;
        repeat (10) @(posedge clk); #1;
        check("held_btn", btn_o, 6'h01);
        rd(8'h10, d); check("edge_set", d, 32'h01);
        check("irq_set", irq_o, 1);

        btn_i = 6'h00;
        repeat (10) @(posedge clk); #1;
        check("release_btn", btn_o, 0);
        wr(8'h10, 32'h1, 4'b0001);
        rd(8'h10, d); check("edge_clr0", d, 32'h0);
        @(posedge clk); #1 btn_i = 6'h01;
        repeat (5) @(posedge clk);
        wr(8'h10, 32'h1, 4'b0001);
        rd(8'h10, d); check("edge_set_wins", d, 32'h01);
        wr(8'h10, 32'h1, 4'b0001);
        check("irq_clr", irq_o, 0);
        rd(8'h10, d); check("edge_clr1", d, 32'h0);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 vsync_i = 1;
            repeat (2) @(posedge clk); #1 vsync_i = 0;
            repeat (2) @(posedge clk);
        end
        repeat (3) @(posedge clk);
        rd(8'h08, d); check("frame3", d, 32'd3);
        @(posedge clk); #1 vsync_i = 1;
        @(posedge clk);
        wr(8'h08, 32'h0, 4'hF);
        rd(8'h08, d); check("frame_wr_wins", d, 32'd0);
        @(posedge clk); #1 vsync_i = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1 vsync_i = 1;
            @(posedge clk); #1 vsync_i = 0;
        end
        repeat (4) @(posedge clk);
        rd(8'h08, d); check("frame300", d, 32'd300);

        @(posedge clk); #1;
        bus_if.wbs_stb_i = 1; bus_if.wbs_cyc_i = 1; bus_if.wbs_adr_i = BASE + 32'h100;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("oow_ack", bus_if.wbs_ack_o, 0);
            check("oow_dat", bus_if.wbs_dat_o, 0);
        end
        bus_if.wbs_stb_i = 0; bus_if.wbs_cyc_i = 0;
        @(posedge clk); #1;
        bus_if.wbs_stb_i = 1; bus_if.wbs_cyc_i = 1; bus_if.wbs_adr_i = BASE;
        @(posedge clk); #1;
        check("rst_mid_ack_hi", bus_if.wbs_ack_o, 1);
        rst = 1; bus_if.wbs_stb_i = 0; bus_if.wbs_cyc_i = 0;
        @(posedge clk); #1;
        check("rst_mid_ack_lo", bus_if.wbs_ack_o, 0);
        rst = 0;
        rd(8'h00, d); check("ctrl_after_rst", d, 32'h3);
        check("core_after_rst", core_rst_o, 1);

        wr(8'h0C, $urandom_range(0, 6), 4'hF);
        wr(8'h00, 32'h0000_3F00, 4'b0010);
        for (int it = 0; it < 3000; it++) begin
            @(posedge clk); #1;
            for (int b = 0; b < 6; b++) if ($urandom_range(0, 7) == 0) btn_i[b] = ~btn_i[b];
            if ($urandom_range(0, 2) == 0) vsync_i = ~vsync_i;
            if ($urandom_range(0, 3) == 0) begin
                logic [7:0]  o;
                logic [31:0] a, v;
                o = 8'($urandom_range(0, 8)) << 2;
                a = BASE + {24'd0, o};
                if ($urandom_range(0, 15) == 0) a = BASE + 32'h200;
                v = (o == 8'h0C) ? $urandom_range(0, 6) : $urandom;
                bus(1'($urandom_range(0, 1)), a, v, 4'($urandom_range(0, 15)), d);
            end
        end
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
